bcd_updown_counter: RTL and testbench
=====================================

BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 The block SHALL have parameter DIGITS, default 2, giving the number of BCD digits (range 1..4).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have port en, input, 1 bit, the count enable.
REQ-005 The block SHALL have port up, input, 1 bit, the count direction: 1 = increment, 0 = decrement.
REQ-006 The block SHALL have port load, input, 1 bit, the parallel-load strobe.
REQ-007 The block SHALL have port load_val, input, 4*DIGITS bits, the BCD value to load; digit 0 is in bits [3:0].
REQ-008 The block SHALL have port q, output, 4*DIGITS bits, the registered BCD count.
REQ-009 The block SHALL have port tc, output, 1 bit, the combinational terminal-count flag.
REQ-010 The block SHALL have port wrap, output, 1 bit, a registered one-cycle pulse.
REQ-011 The block SHALL have port load_err, output, 1 bit, a registered one-cycle pulse.

Function
REQ-012 Each clock edge SHALL apply exactly one action, in priority order: rst, then load, then en, then hold.
REQ-013 When up=1 and en=1, q SHALL increment by 1 in decimal: a digit at 9 goes to 0 and carries into the next digit; otherwise it adds 1.
REQ-014 When up=0 and en=1, q SHALL decrement by 1 in decimal: a digit at 0 goes to 9 and borrows from the next digit; otherwise it subtracts 1.
REQ-015 Up wrap-around SHALL be all-9s -> all-0s (e.g. 99 -> 00); down wrap-around SHALL be all-0s -> all-9s (00 -> 99).
REQ-016 wrap SHALL be 1 in the cycle after an enabled count that wrapped, and 0 otherwise.
REQ-017 tc SHALL equal en AND ((up AND q == all-9s) OR (NOT up AND q == 0)).
REQ-018 When load=1, q SHALL take load_val on the next edge, regardless of en and up.
REQ-019 Any load_val digit greater than 9 SHALL be loaded as 9; all other digits SHALL load unchanged.
REQ-020 load_err SHALL be 1 in the cycle after such a load, and 0 otherwise.
REQ-021 A load SHALL never assert wrap.
REQ-022 When load and en are both 1, the load SHALL win and the count in that cycle SHALL be discarded.
REQ-023 q SHALL always hold valid BCD: every digit in 0..9.
REQ-024 Latency SHALL be one cycle from input to q, wrap and load_err; there is no other pipelining.

Reset
REQ-025 On a clock edge with rst=1, q SHALL become 0, wrap SHALL become 0, and load_err SHALL become 0.
REQ-026 rst SHALL override load and en in the same cycle.
REQ-027 A reset asserted mid-count SHALL take effect on the next edge and leave no residual carry or pulse.
REQ-028 With rst=1, tc SHALL follow REQ-017 evaluated on the reset value of q.

Structure
REQ-029 Shared package bcd_pkg SHALL hold DIGIT_W = 4, DIGIT_MAX = 9 and DIGIT_MIN = 0.
REQ-030 A sub-module bcd_digit SHALL implement one digit: it takes cin/bin, up, en, load, ld_digit and the digit value, and produces the next digit plus carry/borrow out.
REQ-031 The top level SHALL instantiate DIGITS copies of bcd_digit, chained least-significant first.
REQ-032 The top level SHALL contain the wrap and load_err registers and the tc logic.
REQ-033 The carry/borrow chain SHALL be combinational within one cycle, with no ripple across clock cycles.

Verification
REQ-034 Bench scenario: rst=1 for 1 cycle, then en=1, up=1 for 100 cycles -> q steps 00..99, then 00; tc=1 while q=99; wrap=1 exactly once, in the cycle after 99 -> 00.
REQ-035 Bench scenario: rst, then en=1, up=0 -> q goes 00 -> 99 -> 98; wrap pulses once, after 00 -> 99; tc=1 while q=00.
REQ-036 Bench scenario: load=1 with load_val=0x39, then en=1, up=1 -> q=39, then 40 (carry across digit); load_err=0.
REQ-037 Bench scenario: load=1 with load_val=0xA7 -> q=97 and load_err=1 for one cycle; load=1 and en=1 with load_val=0x55 -> q=55 and no count applied.
REQ-038 Bench scenario: counting from q=57, assert rst together with load=1 -> q=00, wrap=0, load_err=0 on the next cycle.
REQ-039 Bench scenario: q=50, en=0 for 5 cycles with up toggling -> q stays 50 and tc=0.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the BCD up/down counter.
package bcd_pkg;

   localparam int unsigned DIGIT_W   = 4;
   localparam int unsigned DIGIT_MAX = 9;
   localparam int unsigned DIGIT_MIN = 0;

   // Force an out-of-range nibble back into decimal range by saturating at 9.
   function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
      return (d > DIGIT_W'(DIGIT_MAX)) ? DIGIT_W'(DIGIT_MAX) : d;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit: next-value and carry/borrow-out logic, purely combinational.
module bcd_digit
   import bcd_pkg::*;
(
   input  logic               cin,
   input  logic               up,
   input  logic               en,
   input  logic               load,
   input  logic [DIGIT_W-1:0] ld_digit,
   input  logic [DIGIT_W-1:0] digit,
   output logic [DIGIT_W-1:0] nxt_c,
   output logic               cout_c,
   output logic               clamp_c
);

   // cin carries the increment request for increments and the borrow for decrements.
   always_comb begin
      nxt_c   = digit;
      cout_c  = 1'b0;
      clamp_c = (ld_digit > DIGIT_W'(DIGIT_MAX));
      if (load) begin
         nxt_c = clamp_digit(ld_digit);
      end else if (en && cin) begin
         if (up) begin
            if (digit >= DIGIT_W'(DIGIT_MAX)) begin
               nxt_c  = DIGIT_W'(DIGIT_MIN);
               cout_c = 1'b1;
            end else begin
               nxt_c = digit + DIGIT_W'(1);
            end
         end else begin
            if (digit == DIGIT_W'(DIGIT_MIN)) begin
               nxt_c  = DIGIT_W'(DIGIT_MAX);
               cout_c = 1'b1;
            end else begin
               nxt_c = digit - DIGIT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with saturating parallel load,
// wrap and load-error pulses, and a combinational terminal-count flag.
module bcd_updown_counter
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic                        up,
   input  logic                        load,
   input  logic [DIGIT_W*DIGITS-1:0]   load_val,
   output logic [DIGIT_W*DIGITS-1:0]   q,
   output logic                        tc,
   output logic                        wrap,
   output logic                        load_err
);

   localparam int unsigned QW = DIGIT_W * DIGITS;
   localparam logic [QW-1:0] ALL_NINES = {DIGITS{DIGIT_W'(DIGIT_MAX)}};

   logic [QW-1:0]     q_nxt;
   logic [DIGITS-1:0] clamp;
   logic              msd_cout;

   // Ripple chain least-significant first; the LSD always sees a step request.
   for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      logic cin;
      logic cout;

      if (i == 0) begin : g_lsd
         assign cin = 1'b1;
      end else begin : g_chain
         assign cin = g_dig[i-1].cout;
      end

      bcd_digit u_digit (
         .cin      (cin),
         .up       (up),
         .en       (en),
         .load     (load),
         .ld_digit (load_val[i*DIGIT_W +: DIGIT_W]),
         .digit    (q[i*DIGIT_W +: DIGIT_W]),
         .nxt_c    (q_nxt[i*DIGIT_W +: DIGIT_W]),
         .cout_c   (cout),
         .clamp_c  (clamp[i])
      );
   end

   // Carry out of the top digit only happens on a full-range wrap; loads force it low.
   assign msd_cout = g_dig[DIGITS-1].cout;

   always_ff @(posedge clk) begin
      if (rst) begin
         q        <= '0;
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         q        <= q_nxt;
         wrap     <= msd_cout;
         load_err <= load & (|clamp);
      end
   end

   assign tc = en & ((up & (q == ALL_NINES)) | (~up & (q == '0)));

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboarded random and directed bench for the 2-digit BCD up/down counter.
module tb_bcd_updown_counter;

   localparam int unsigned D   = 2;
   localparam int unsigned MOD = 100;
   localparam int unsigned QW  = 4 * D;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          en = 1'b0;
   logic          up = 1'b0;
   logic          load = 1'b0;
   logic [QW-1:0] load_val = '0;
   logic [QW-1:0] q;
   logic          tc;
   logic          wrap;
   logic          load_err;

   typedef struct {
      bit            tc_chk;
      bit            tc_exp;
      logic [QW-1:0] q_exp;
      bit            wrap_exp;
      bit            err_exp;
   } exp_t;

   exp_t sb[$];

   int n_cmp = 0;
   int n_err = 0;

   // Reference state as a plain integer count.
   int m_n     = 0;
   bit m_known = 1'b0;

   bcd_updown_counter #(.DIGITS(D)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .q        (q),
      .tc       (tc),
      .wrap     (wrap),
      .load_err (load_err)
   );

   always #5 clk = ~clk;

   function automatic logic [QW-1:0] to_bcd(input int n);
      logic [QW-1:0] b;
      int p;
      b = '0;
      p = 1;
      for (int i = 0; i < D; i++) begin
         b[4*i +: 4] = 4'((n / p) % 10);
         p = p * 10;
      end
      return b;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Drive one cycle of inputs and push the outcome the reference model predicts.
   task automatic step(input bit r, input bit ld, input logic [QW-1:0] lv, input bit e, input bit u);
      exp_t x;
      int   nv;
      int   p;
      bit   bad;
      @(posedge clk);
      #2;
      rst      = r;
      load     = ld;
      load_val = lv;
      en       = e;
      up       = u;
      x.tc_chk = m_known;
      x.tc_exp = e && (u ? (m_n == MOD - 1) : (m_n == 0));
      x.wrap_exp = 1'b0;
      x.err_exp  = 1'b0;
      if (r) begin
         m_n     = 0;
         m_known = 1'b1;
      end else if (ld) begin
         nv  = 0;
         p   = 1;
         bad = 1'b0;
         for (int i = 0; i < D; i++) begin
            int d;
            d = int'(lv[4*i +: 4]);
            if (d > 9) begin
               d   = 9;
               bad = 1'b1;
            end
            nv = nv + d * p;
            p  = p * 10;
         end
         m_n       = nv;
         m_known   = 1'b1;
         x.err_exp = bad;
      end else if (e) begin
         if (u) begin
            x.wrap_exp = (m_n == MOD - 1);
            m_n = (m_n + 1) % MOD;
         end else begin
            x.wrap_exp = (m_n == 0);
            m_n = (m_n + MOD - 1) % MOD;
         end
      end
      x.q_exp = to_bcd(m_n);
      sb.push_back(x);
   endtask

   // Monitor: tc is checked mid-cycle against current inputs, registered outputs after the edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.tc_chk) chk("tc", 32'(tc), 32'(e.tc_exp));
            @(posedge clk);
            #1;
            chk("q", 32'(q), 32'(e.q_exp));
            chk("wrap", 32'(wrap), 32'(e.wrap_exp));
            chk("load_err", 32'(load_err), 32'(e.err_exp));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout at %0t", $time);
      $fatal(1, "bench timeout");
   end

   initial begin
      // Reset then count up through the full range and one wrap.
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 100; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b1);

      // Reset then count down across the bottom wrap.
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      step(1'b0, 1'b0, '0, 1'b1, 1'b0);

      // Load 39 then carry across the digit boundary.
      step(1'b0, 1'b1, 8'h39, 1'b0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b1, 1'b1);

      // Saturating load, then load winning over count.
      step(1'b0, 1'b1, 8'hA7, 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'h55, 1'b1, 1'b1);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);

      // Count to 57, then reset overriding a load.
      step(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b1, 1'b1);
      step(1'b0, 1'b0, '0, 1'b1, 1'b1);
      step(1'b1, 1'b1, 8'h33, 1'b1, 1'b1);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);

      // Hold at 50 with direction toggling.
      step(1'b0, 1'b1, 8'h50, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b0, 1'(i));

      // Hold at the boundaries with en low: tc must stay low.
      step(1'b0, 1'b1, 8'h99, 1'b0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);

      // Randomised mix of all controls.
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 25) == 0, ($urandom % 6) == 0, QW'($urandom),
              ($urandom % 4) != 0, ($urandom % 3) != 0);
      end

      for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      #3;
      if (sb.size() > 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
